// File: rtl/ws2812b_pixel_buffer.sv
// ws2812b_pixel_buffer
// Double-banked GRB pixel store. The CPU writes bytes into the back bank.
// A commit swaps the banks and streams the new front bank, one 24-bit
// pixel per valid/ready handshake, into the WS2812B serial driver.
// Optional feature macro: WS2812B_BRIGHTNESS_EN adds a SCALE state that
// applies the global brightness to every channel before presenting it.
module ws2812b_pixel_buffer #(
  parameter int NUM_LEDS = 120,
  parameter int LED_W    = 7
) (
  input  logic             clk,
  input  logic             glbl_reset_n,
  input  logic             wr_en,
  input  logic [LED_W-1:0] wr_led,
  input  logic [1:0]       wr_chan,
  input  logic [7:0]       wr_data,
  input  logic             commit,
  input  logic [7:0]       brightness,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [23:0]      pix_data,
  output logic             pix_last,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       frame_count
);

  localparam logic [LED_W:0]   NUM_LEDS_W = (LED_W+1)'(NUM_LEDS);
  localparam logic [LED_W-1:0] LAST_IDX   = LED_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SCALE,
    S_PRESENT
  } state_t;

  state_t           state;
  logic             front_sel;
  logic             pending;
  logic [LED_W-1:0] idx;
  logic [23:0]      rd_data;
  logic             wr_ok;

  logic [23:0] bank_mem [0:1][0:NUM_LEDS-1];

`ifdef WS2812B_BRIGHTNESS_EN
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(c) * (16'(b) + 16'd1);
    return prod[15:8];
  endfunction
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  assign wr_ok = wr_en && ({1'b0, wr_led} < NUM_LEDS_W) && (wr_chan != 2'd3);

  // Byte writes always target the back bank; the front bank is only read while streaming
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      case (wr_chan)
        2'd0:    bank_mem[~front_sel][wr_led][23:16] <= wr_data;
        2'd1:    bank_mem[~front_sel][wr_led][15:8]  <= wr_data;
        2'd2:    bank_mem[~front_sel][wr_led][7:0]   <= wr_data;
        default: ;
      endcase
    end
    if (state == S_FETCH) begin
      rd_data <= bank_mem[front_sel][idx];
    end
  end

  // Frame sequencer: bank swap on commit, fetch/present each pixel, chain pending frames
  always_ff @(posedge clk or negedge glbl_reset_n) begin
    if (!glbl_reset_n) begin
      state       <= S_IDLE;
      front_sel   <= 1'b0;
      pending     <= 1'b0;
      idx         <= '0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_last    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      if (commit && (state != S_IDLE)) begin
        pending <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (commit) begin
            front_sel <= ~front_sel;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          pix_data <= rd_data;
          pix_last <= (idx == LAST_IDX);
`ifdef WS2812B_BRIGHTNESS_EN
          state    <= S_SCALE;
`else
          pix_valid <= 1'b1;
          state     <= S_PRESENT;
`endif
        end
`ifdef WS2812B_BRIGHTNESS_EN
        S_SCALE: begin
          pix_data  <= {scale_chan(pix_data[23:16], brightness),
                        scale_chan(pix_data[15:8],  brightness),
                        scale_chan(pix_data[7:0],   brightness)};
          pix_valid <= 1'b1;
          state     <= S_PRESENT;
        end
`endif
        S_PRESENT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            if (idx == LAST_IDX) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 8'd1;
              if (pending || commit) begin
                front_sel <= ~front_sel;
                idx       <= '0;
                pending   <= 1'b0;
                state     <= S_FETCH;
              end else begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end else begin
              idx   <= idx + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_pixel_buffer.sv
// tb_ws2812b_pixel_buffer
// Self-checking bench for ws2812b_pixel_buffer: a constant vector table,
// hand sequences for stalls, pending commits and mid-frame reset, and
// randomized writes checked against a two-image frame model.
module tb_ws2812b_pixel_buffer;

  localparam int NUM_LEDS = 120;
  localparam int LED_W    = 7;
`ifdef WS2812B_BRIGHTNESS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             glbl_reset_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [LED_W-1:0] wr_led = '0;
  logic [1:0]       wr_chan = '0;
  logic [7:0]       wr_data = '0;
  logic             commit = 1'b0;
  logic [7:0]       brightness = 8'hFF;
  logic             pix_valid;
  logic             pix_ready = 1'b0;
  logic [23:0]      pix_data;
  logic             pix_last;
  logic             busy;
  logic             frame_done;
  logic [7:0]       frame_count;

  always #5 clk = ~clk;

  ws2812b_pixel_buffer #(.NUM_LEDS(NUM_LEDS), .LED_W(LED_W)) dut (
    .clk(clk), .glbl_reset_n(glbl_reset_n), .wr_en(wr_en), .wr_led(wr_led),
    .wr_chan(wr_chan), .wr_data(wr_data), .commit(commit), .brightness(brightness),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_last(pix_last), .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  typedef struct {
    int          led;
    int          chan;
    logic [7:0]  data;
    int          chk_led;
    logic [23:0] exp_pix;
  } vec_t;

  vec_t vecs [10];

  int vec_count = 0;
  int miscount  = 0;

  // Reference model: the image the next commit shows, the image on display
  logic [23:0] back_img  [NUM_LEDS];
  logic [23:0] shown_img [NUM_LEDS];
  logic [23:0] cap       [NUM_LEDS];
  bit          m_busy    = 1'b0;
  bit          m_pending = 1'b0;
  int          m_swaps   = 0;
  logic [7:0]  m_count   = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelSwap();
    logic [23:0] tmp;
    for (int i = 0; i < NUM_LEDS; i++) begin
      tmp          = shown_img[i];
      shown_img[i] = back_img[i];
      back_img[i]  = tmp;
    end
    m_swaps++;
  endtask

  function automatic logic [23:0] expPixel(input int i);
    logic [23:0] c;
    c = shown_img[i];
`ifdef WS2812B_BRIGHTNESS_EN
    return {8'((int'(c[23:16]) * (int'(brightness) + 1)) / 256),
            8'((int'(c[15:8])  * (int'(brightness) + 1)) / 256),
            8'((int'(c[7:0])   * (int'(brightness) + 1)) / 256)};
`else
    return c;
`endif
  endfunction

  task automatic writeByte(input int led, input int chan, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_led  = LED_W'(led);
    wr_chan = 2'(chan);
    wr_data = data;
    tick();
    wr_en = 1'b0;
    if (led < NUM_LEDS && chan != 3) back_img[led][(2-chan)*8 +: 8] = data;
  endtask

  task automatic writePixel(input int led, input logic [23:0] pix);
    writeByte(led, 0, pix[23:16]);
    writeByte(led, 1, pix[15:8]);
    writeByte(led, 2, pix[7:0]);
  endtask

  task automatic fillBack(input bit rnd);
    for (int i = 0; i < NUM_LEDS; i++) writePixel(i, rnd ? 24'($urandom) : 24'h0);
  endtask

  task automatic applyStimulus(input vec_t v);
    writeByte(v.led, v.chan, v.data);
  endtask

  task automatic doCommit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    if (!m_busy) begin
      modelSwap();
      m_busy = 1'b1;
      checkOutput("busy_on_commit", 32'(busy), 32'd1);
    end else begin
      m_pending = 1'b1;
    end
  endtask

  task automatic commitWithWrite(input int led, input int chan, input logic [7:0] data);
    commit  = 1'b1;
    wr_en   = 1'b1;
    wr_led  = LED_W'(led);
    wr_chan = 2'(chan);
    wr_data = data;
    tick();
    commit = 1'b0;
    wr_en  = 1'b0;
    back_img[led][(2-chan)*8 +: 8] = data;
    modelSwap();
    m_busy = 1'b1;
  endtask

  task automatic doReset();
    glbl_reset_n = 1'b0;
    #1;
    checkOutput("rst_pix_valid",   32'(pix_valid),   32'd0);
    checkOutput("rst_busy",        32'(busy),        32'd0);
    checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
    checkOutput("rst_frame_done",  32'(frame_done),  32'd0);
    checkOutput("rst_pix_last",    32'(pix_last),    32'd0);
    checkOutput("rst_pix_data",    32'(pix_data),    32'd0);
    tick();
    tick();
    glbl_reset_n = 1'b1;
    tick();
    m_busy    = 1'b0;
    m_pending = 1'b0;
    m_count   = '0;
    if (m_swaps % 2 == 1) modelSwap();
    m_swaps = 0;
  endtask

  // Streams one frame, checking every pixel, its latency and the frame-end signalling
  task automatic streamFrame(input int stall_at, input int inject_at, input int reset_at, input bit rand_ready);
    int waited;
    for (int p = 0; p < NUM_LEDS; p++) begin
      waited    = 0;
      pix_ready = 1'b0;
      while (!pix_valid && waited < 8) begin
        tick();
        waited++;
      end
      checkOutput("pixel_latency", 32'(waited), 32'(LAT));
      if (!pix_valid) return;
      cap[p] = pix_data;
      checkOutput("pix_data", 32'(pix_data), 32'(expPixel(p)));
      checkOutput("pix_last", 32'(pix_last), 32'(p == NUM_LEDS - 1));
      checkOutput("busy_in_frame", 32'(busy), 32'd1);
      if (p == reset_at) begin
        doReset();
        return;
      end
      if (p == inject_at) begin
        doCommit();
        writePixel(0, 24'h010203);
        doCommit();
        checkOutput("hold_during_writes", 32'(pix_data), 32'(cap[p]));
      end
      if (p == stall_at) begin
        repeat (20) begin
          tick();
          checkOutput("stall_valid", 32'(pix_valid), 32'd1);
          checkOutput("stall_data",  32'(pix_data),  32'(cap[p]));
        end
      end
      if (rand_ready) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          checkOutput("wait_data", 32'(pix_data), 32'(cap[p]));
        end
      end
      pix_ready = 1'b1;
      tick();
      pix_ready = 1'b0;
      checkOutput("valid_drop", 32'(pix_valid), 32'd0);
      if (p == NUM_LEDS - 1) begin
        m_count = m_count + 8'd1;
        checkOutput("frame_done_pulse", 32'(frame_done),  32'd1);
        checkOutput("frame_count",      32'(frame_count), 32'(m_count));
        checkOutput("busy_frame_end",   32'(busy),        32'(m_pending));
        if (m_pending) begin
          modelSwap();
          m_pending = 1'b0;
        end else begin
          m_busy = 1'b0;
          tick();
          checkOutput("frame_done_width", 32'(frame_done), 32'd0);
          checkOutput("idle_valid",       32'(pix_valid),  32'd0);
        end
      end else begin
        checkOutput("no_frame_done", 32'(frame_done), 32'd0);
      end
    end
  endtask

  // Main sequence: reset, constant table, hand corner cases, random frames
  initial begin
    vecs[0] = '{0,   0, 8'h12, 0,   24'h123456};
    vecs[1] = '{0,   1, 8'h34, 0,   24'h123456};
    vecs[2] = '{0,   2, 8'h56, 0,   24'h123456};
    vecs[3] = '{119, 0, 8'hFF, 119, 24'hFF00AA};
    vecs[4] = '{119, 1, 8'h00, 119, 24'hFF00AA};
    vecs[5] = '{119, 2, 8'hAA, 119, 24'hFF00AA};
    vecs[6] = '{3,   3, 8'h99, 3,   24'h000000};
    vecs[7] = '{120, 1, 8'h77, 1,   24'h000000};
    vecs[8] = '{7,   2, 8'hC3, 7,   24'h0000C3};
    vecs[9] = '{64,  1, 8'h80, 64,  24'h008000};

    tick();
    tick();
    checkOutput("reset_pix_valid",   32'(pix_valid),   32'd0);
    checkOutput("reset_pix_data",    32'(pix_data),    32'd0);
    checkOutput("reset_pix_last",    32'(pix_last),    32'd0);
    checkOutput("reset_busy",        32'(busy),        32'd0);
    checkOutput("reset_frame_done",  32'(frame_done),  32'd0);
    checkOutput("reset_frame_count", 32'(frame_count), 32'd0);
    glbl_reset_n = 1'b1;
    tick();

`ifndef WS2812B_BRIGHTNESS_EN
    brightness = 8'h3C;
`endif

    $display("[TB] bring both banks to a known state");
    fillBack(1'b0);
    doCommit();
    streamFrame(-1, -1, -1, 1'b0);
    fillBack(1'b0);

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);
    doCommit();
    streamFrame(-1, -1, -1, 1'b0);
    for (int i = 0; i < 10; i++) checkOutput("table_pixel", 32'(cap[vecs[i].chk_led]), 32'(vecs[i].exp_pix));

    $display("[TB] stall on pixel 5");
    fillBack(1'b1);
    doCommit();
    streamFrame(5, -1, -1, 1'b0);

    $display("[TB] double commit mid-frame chains one back-to-back frame");
    fillBack(1'b1);
    doCommit();
    streamFrame(-1, 30, -1, 1'b0);
    streamFrame(-1, -1, -1, 1'b0);
    checkOutput("chained_first_pixel", 32'(cap[0]), 32'h010203);

    $display("[TB] commit and write in the same cycle");
    commitWithWrite(5, 1, 8'hEE);
    streamFrame(-1, -1, -1, 1'b1);

    $display("[TB] reset during pixel 10");
    doCommit();
    streamFrame(-1, -1, 10, 1'b0);
    doCommit();
    streamFrame(-1, -1, -1, 1'b0);

`ifdef WS2812B_BRIGHTNESS_EN
    $display("[TB] brightness scaling");
    brightness = 8'h7F;
    writePixel(0, 24'hFF8002);
    doCommit();
    streamFrame(-1, -1, -1, 1'b0);
    checkOutput("bright_7f", 32'(cap[0]), 32'h7F4001);
    brightness = 8'hFF;
    writePixel(0, 24'hFF8002);
    doCommit();
    streamFrame(-1, -1, -1, 1'b0);
    checkOutput("bright_ff", 32'(cap[0]), 32'hFF8002);
`endif

    $display("[TB] randomized frames");
    for (int f = 0; f < 3; f++) begin
      int nw;
      nw = $urandom_range(20, 80);
      for (int k = 0; k < nw; k++) writeByte($urandom_range(0, 127), $urandom_range(0, 3), 8'($urandom));
      brightness = 8'($urandom);
      doCommit();
      streamFrame(-1, -1, -1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscount);
    $finish;
  end

  // Bounds the whole run in case the design stops responding
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d checks so far", vec_count);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
